// File: rtl/apb_matmul_accel_pkg.sv
// apb_matmul_pkg
// Shared constants, register layout and FSM state type for the APB
// matrix-multiply accelerator. Every rtl/ file imports this package.
// No ports (package only).
package apb_matmul_pkg;

    localparam int DW          = 16;                 // element width, signed
    localparam int BW          = 64;                 // APB data width
    localparam int ADDR_W      = 32;                 // APB address width
    localparam int SP_NTARGETS = 4;                  // scratchpad result matrices
    localparam int MAX_DIM     = BW / DW;            // elements per row
    localparam int ACC_W       = 2 * DW + 2;         // MAC accumulator width
    localparam int IDX_W       = $clog2(MAX_DIM);    // row/column index width
    localparam int TGT_W       = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1;

    // Region codes decoded from paddr_i[11:8]
    localparam logic [3:0] REGION_CONTROL    = 4'd0;
    localparam logic [3:0] REGION_OPERAND_A  = 4'd1;
    localparam logic [3:0] REGION_OPERAND_B  = 4'd2;
    localparam logic [3:0] REGION_FLAGS      = 4'd3;
    localparam logic [3:0] REGION_SCRATCHPAD = 4'd4;

    // CONTROL register bit positions
    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_WR_TGT_LSB  = 1;
    localparam int CTRL_RD_TGT_LSB  = 3;
    localparam int CTRL_BIAS_EN_BIT = 5;
    localparam int CTRL_N_LSB       = 8;
    localparam int CTRL_K_LSB       = 10;
    localparam int CTRL_M_LSB       = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Stored CONTROL fields; START is a pulse and is never stored
    typedef struct packed {
        logic [1:0] m_m1;
        logic [1:0] k_m1;
        logic [1:0] n_m1;
        logic       bias_en;
        logic [1:0] rd_tgt;
        logic [1:0] wr_tgt;
    } ctrl_t;

    // Place the stored CONTROL fields back at their bus bit positions
    function automatic logic [BW-1:0] ctrl_to_word(input ctrl_t c);
        logic [BW-1:0] w;
        w = '0;
        w[CTRL_WR_TGT_LSB +: 2]  = c.wr_tgt;
        w[CTRL_RD_TGT_LSB +: 2]  = c.rd_tgt;
        w[CTRL_BIAS_EN_BIT]      = c.bias_en;
        w[CTRL_N_LSB +: 2]       = c.n_m1;
        w[CTRL_K_LSB +: 2]       = c.k_m1;
        w[CTRL_M_LSB +: 2]       = c.m_m1;
        return w;
    endfunction

endpackage

// File: rtl/apb_matmul_accel_if.sv
// apb_matmul_accel_if
// APB bus bundle for the matrix-multiply accelerator.
//   psel_i, penable_i, pwrite_i : APB control (master -> slave)
//   pstrb_i                     : per-element write strobe
//   pwdata_i, paddr_i           : write data and byte address
//   pready_o, pslverr_o         : completion and error (slave -> master)
//   prdata_o                    : read data
// Modports: slave (accelerator side), master (host/bench side).
interface apb_matmul_accel_if;
    import apb_matmul_pkg::*;

    logic               psel_i;
    logic               penable_i;
    logic               pwrite_i;
    logic [MAX_DIM-1:0] pstrb_i;
    logic [BW-1:0]      pwdata_i;
    logic [ADDR_W-1:0]  paddr_i;
    logic               pready_o;
    logic               pslverr_o;
    logic [BW-1:0]      prdata_o;

    modport slave (
        input  psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i, paddr_i,
        output pready_o, pslverr_o, prdata_o
    );

    modport master (
        output psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i, paddr_i,
        input  pready_o, pslverr_o, prdata_o
    );

endinterface

// File: rtl/apb_matmul_accel_mac_pe.sv
// matmul_mac_pe
// Signed DW x DW multiply-accumulate element with optional final bias add
// and signed-DW overflow detection on the complete sum.
//   clk, rst_n : clock and synchronous active-low reset
//   en         : perform one MAC step this cycle
//   first      : this step starts a new element (accumulator treated as 0)
//   a, b       : signed operands
//   bias_en    : add sign-extended bias into the complete sum
//   bias       : bias element
//   result     : low DW bits of the complete sum (valid on the last step)
//   overflow   : complete sum is outside the signed DW range
module matmul_mac_pe
    import apb_matmul_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          first,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          bias_en,
    input  logic [DW-1:0] bias,
    output logic [DW-1:0] result,
    output logic          overflow
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] product;
    logic signed [ACC_W-1:0] partial;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] full_sum;
    logic [ACC_W-DW:0]       top_bits;

    // The running sum for this step is combinational so that the final
    // element value is available in the same cycle as the last product.
    always_comb begin
        product  = $signed({{(ACC_W-DW){a[DW-1]}}, a}) *
                   $signed({{(ACC_W-DW){b[DW-1]}}, b});
        partial  = (first ? '0 : acc) + product;
        bias_ext = bias_en ? $signed({{(ACC_W-DW){bias[DW-1]}}, bias}) : '0;
        full_sum = partial + bias_ext;
        result   = full_sum[DW-1:0];
        // In range exactly when every bit from DW-1 upward is a sign copy
        top_bits = full_sum[ACC_W-1:DW-1];
        overflow = ~((&top_bits) | ~(|top_bits));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= partial;
        end
    end

endmodule

// File: rtl/apb_matmul_accel.sv
// apb_matmul_accel
// APB slave matrix-multiply accelerator: C = A x B (+ bias) into one of
// SP_NTARGETS scratchpad matrices, one MAC per clock.
//   clk_i     : clock, rising edge
//   reset_ni  : synchronous active-low reset
//   bus       : APB slave modport (select/enable/write/strobe/data/address,
//               ready/error/read data)
//   busy_o    : computation in progress
// Build option: define MATMUL_BIAS_EN to include the bias path
// (CONTROL BIAS_EN / RD_TGT). Without it those fields are write-ignored.
module apb_matmul_accel
    import apb_matmul_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_ni,
    apb_matmul_accel_if.slave   bus,
    output logic                busy_o
);

    logic [DW-1:0]          a_mem  [MAX_DIM][MAX_DIM];
    logic [DW-1:0]          b_mem  [MAX_DIM][MAX_DIM];
    logic [DW-1:0]          sp_mem [SP_NTARGETS][MAX_DIM][MAX_DIM];
    logic [MAX_DIM*MAX_DIM-1:0] flags;
    ctrl_t                  ctrl;
    ctrl_t                  ctrl_wdata;
    state_t                 state, state_next;
    logic [IDX_W-1:0]       ci, cj, ck;

    logic                   access, region_ok, region_ro, bus_err;
    logic                   wr_ok, rd_ok, start_go;
    logic [3:0]             region;
    logic [IDX_W-1:0]       row;
    logic [TGT_W-1:0]       tgt;
    logic [BW-1:0]          rd_word;
    logic                   mac_en, mac_first, mac_last, store;
    logic                   use_bias;
    logic [DW-1:0]          bias_val;
    logic [DW-1:0]          mac_result;
    logic                   mac_ovf;
    logic                   unused_addr;

    assign unused_addr = ^{bus.paddr_i[ADDR_W-1:12], bus.paddr_i[5], bus.paddr_i[2:0]};

    // Address decode and error classification. Anything while busy is
    // rejected, as are unknown regions and writes to read-only regions.
    always_comb begin
        access    = bus.psel_i & bus.penable_i;
        region    = bus.paddr_i[11:8];
        row       = bus.paddr_i[4:3];
        tgt       = bus.paddr_i[6 +: TGT_W];
        region_ok = region <= REGION_SCRATCHPAD;
        region_ro = (region == REGION_FLAGS) || (region == REGION_SCRATCHPAD);
        bus_err   = access & (busy_o | ~region_ok | (bus.pwrite_i & region_ro));
        wr_ok     = access & bus.pwrite_i & ~bus_err;
        rd_ok     = access & ~bus.pwrite_i & ~bus_err;
        start_go  = wr_ok & (region == REGION_CONTROL) & bus.pwdata_i[CTRL_START_BIT];
    end

    // CONTROL write data as it will be stored; bias fields only exist
    // when the bias path is built in.
    always_comb begin
        ctrl_wdata        = '0;
        ctrl_wdata.wr_tgt = bus.pwdata_i[CTRL_WR_TGT_LSB +: 2];
        ctrl_wdata.n_m1   = bus.pwdata_i[CTRL_N_LSB +: 2];
        ctrl_wdata.k_m1   = bus.pwdata_i[CTRL_K_LSB +: 2];
        ctrl_wdata.m_m1   = bus.pwdata_i[CTRL_M_LSB +: 2];
`ifdef MATMUL_BIAS_EN
        ctrl_wdata.rd_tgt  = bus.pwdata_i[CTRL_RD_TGT_LSB +: 2];
        ctrl_wdata.bias_en = bus.pwdata_i[CTRL_BIAS_EN_BIT];
`endif
    end

`ifdef MATMUL_BIAS_EN
    // Bias is read from the old scratchpad contents of the element being
    // stored, so WR_TGT == RD_TGT naturally reads before it overwrites.
    assign use_bias = ctrl.bias_en;
    assign bias_val = sp_mem[ctrl.rd_tgt[TGT_W-1:0]][ci][cj];
`else
    assign use_bias = 1'b0;
    assign bias_val = '0;
`endif

    // Read mux and APB response; prdata is forced to zero unless this is
    // an accepted read in the access phase.
    always_comb begin
        rd_word = '0;
        case (region)
            REGION_CONTROL:    rd_word = ctrl_to_word(ctrl);
            REGION_OPERAND_A:  for (int e = 0; e < MAX_DIM; e++)
                                   rd_word[e*DW +: DW] = a_mem[row][e[IDX_W-1:0]];
            REGION_OPERAND_B:  for (int e = 0; e < MAX_DIM; e++)
                                   rd_word[e*DW +: DW] = b_mem[row][e[IDX_W-1:0]];
            REGION_FLAGS:      rd_word[MAX_DIM*MAX_DIM-1:0] = flags;
            REGION_SCRATCHPAD: for (int e = 0; e < MAX_DIM; e++)
                                   rd_word[e*DW +: DW] = sp_mem[tgt][row][e[IDX_W-1:0]];
            default:           rd_word = '0;
        endcase
        bus.pready_o  = access;
        bus.pslverr_o = bus_err;
        bus.prdata_o  = rd_ok ? rd_word : '0;
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: the run ends on the last k of element (N-1, M-1)
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start_go) state_next = ST_COMPUTE;
            ST_COMPUTE: if (mac_last && ci == ctrl.n_m1 && cj == ctrl.m_m1)
                            state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_o    = state != ST_IDLE;
        mac_en    = state == ST_COMPUTE;
        mac_first = ck == '0;
        mac_last  = ck == ctrl.k_m1;
        store     = mac_en & mac_last;
    end

    // Loop counters walk k fastest, then j, then i
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            ci <= '0;
            cj <= '0;
            ck <= '0;
        end else if (start_go) begin
            ci <= '0;
            cj <= '0;
            ck <= '0;
        end else if (mac_en) begin
            if (mac_last) begin
                ck <= '0;
                if (cj == ctrl.m_m1) begin
                    cj <= '0;
                    ci <= ci + 1'b1;
                end else begin
                    cj <= cj + 1'b1;
                end
            end else begin
                ck <= ck + 1'b1;
            end
        end
    end

    // Register file, operands, scratchpad and flags. A start clears the
    // flags and zeroes the part of the target outside the new N x M.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            ctrl  <= '0;
            flags <= '0;
            for (int i = 0; i < MAX_DIM; i++) begin
                for (int j = 0; j < MAX_DIM; j++) begin
                    a_mem[i][j] <= '0;
                    b_mem[i][j] <= '0;
                    for (int t = 0; t < SP_NTARGETS; t++)
                        sp_mem[t][i][j] <= '0;
                end
            end
        end else begin
            if (wr_ok) begin
                case (region)
                    REGION_CONTROL: ctrl <= ctrl_wdata;
                    REGION_OPERAND_A:
                        for (int e = 0; e < MAX_DIM; e++)
                            if (bus.pstrb_i[e])
                                a_mem[row][e[IDX_W-1:0]] <= bus.pwdata_i[e*DW +: DW];
                    REGION_OPERAND_B:
                        for (int e = 0; e < MAX_DIM; e++)
                            if (bus.pstrb_i[e])
                                b_mem[row][e[IDX_W-1:0]] <= bus.pwdata_i[e*DW +: DW];
                    default: ;
                endcase
            end
            if (start_go) begin
                flags <= '0;
                for (int i = 0; i < MAX_DIM; i++)
                    for (int j = 0; j < MAX_DIM; j++)
                        if (i > int'(ctrl_wdata.n_m1) || j > int'(ctrl_wdata.m_m1))
                            sp_mem[ctrl_wdata.wr_tgt[TGT_W-1:0]][i[IDX_W-1:0]][j[IDX_W-1:0]] <= '0;
            end
            if (store) begin
                sp_mem[ctrl.wr_tgt[TGT_W-1:0]][ci][cj] <= mac_result;
                flags[{ci, cj}]                        <= mac_ovf;
            end
        end
    end

    matmul_mac_pe u_mac (
        .clk      (clk_i),
        .rst_n    (reset_ni),
        .en       (mac_en),
        .first    (mac_first),
        .a        (a_mem[ci][ck]),
        .b        (b_mem[ck][cj]),
        .bias_en  (use_bias),
        .bias     (bias_val),
        .result   (mac_result),
        .overflow (mac_ovf)
    );

endmodule

// File: tb/tb_apb_matmul_accel.sv
// tb_apb_matmul_accel
// Scoreboard bench for apb_matmul_accel: expected APB responses are queued
// as each transfer is driven and compared when the access phase completes.
// A behavioural model of the register file and matrix product supplies
// every expected value. Honours MATMUL_BIAS_EN like the design.
module tb_apb_matmul_accel;
    import apb_matmul_pkg::*;

    logic clk_i    = 1'b0;
    logic reset_ni = 1'b0;
    logic busy_o;

    apb_matmul_accel_if bus ();

    apb_matmul_accel dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .bus      (bus),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    // Behavioural model state
    logic [15:0] a_m  [4][4];
    logic [15:0] b_m  [4][4];
    logic [15:0] sp_m [4][4][4];
    logic [15:0] flags_m;
    logic [63:0] ctrl_m;

`ifdef MATMUL_BIAS_EN
    localparam logic [63:0] CTRL_MASK = 64'h3F3E;
    localparam bit          BIAS_BUILD = 1'b1;
`else
    localparam logic [63:0] CTRL_MASK = 64'h3F06;
    localparam bit          BIAS_BUILD = 1'b0;
`endif

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] mk_addr(input int region, input int tgt, input int row);
        return 32'((region << 8) | (tgt << 6) | (row << 3));
    endfunction

    function automatic logic [63:0] model_read(input logic [31:0] addr);
        logic [63:0] w;
        int r;
        int t;
        w = '0;
        r = int'(addr[4:3]);
        t = int'(addr[7:6]);
        case (int'(addr[11:8]))
            0: w = ctrl_m;
            1: for (int e = 0; e < 4; e++) w[e*16 +: 16] = a_m[r][e];
            2: for (int e = 0; e < 4; e++) w[e*16 +: 16] = b_m[r][e];
            3: w[15:0] = flags_m;
            4: for (int e = 0; e < 4; e++) w[e*16 +: 16] = sp_m[t][r][e];
            default: w = '0;
        endcase
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a_m[i][j] = '0;
                b_m[i][j] = '0;
                for (int t = 0; t < 4; t++) sp_m[t][i][j] = '0;
            end
        flags_m = '0;
        ctrl_m  = '0;
    endtask

    // One APB transfer; the matching expectation is popped in the access phase
    task automatic applyStimulus(input logic write, input logic [31:0] addr,
                                 input logic [63:0] data, input logic [3:0] strb);
        exp_t e;
        @(posedge clk_i); #1;
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = write;
        bus.paddr_i   = addr;
        bus.pwdata_i  = data;
        bus.pstrb_i   = strb;
        @(posedge clk_i); #1;
        bus.penable_i = 1'b1;
        @(negedge clk_i);
        if (exp_q.size() == 0) begin
            checkOutput("scoreboard_underflow", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            checkOutput({e.tag, "_pready"}, 64'(bus.pready_o), 64'd1);
            checkOutput({e.tag, "_rdata"}, bus.prdata_o, e.data);
            checkOutput({e.tag, "_slverr"}, 64'(bus.pslverr_o), 64'(e.err));
        end
        @(posedge clk_i); #1;
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] addr);
        exp_t e;
        e.tag  = tag;
        e.err  = int'(addr[11:8]) > 4;
        e.data = e.err ? 64'd0 : model_read(addr);
        exp_q.push_back(e);
        applyStimulus(1'b0, addr, 64'd0, 4'hF);
    endtask

    task automatic bus_read_err(input string tag, input logic [31:0] addr);
        exp_t e;
        e.tag  = tag;
        e.err  = 1'b1;
        e.data = 64'd0;
        exp_q.push_back(e);
        applyStimulus(1'b0, addr, 64'd0, 4'hF);
    endtask

    task automatic bus_write(input string tag, input logic [31:0] addr,
                             input logic [63:0] data, input logic [3:0] strb,
                             input logic exp_err);
        exp_t e;
        int   r;
        e.tag  = tag;
        e.err  = exp_err;
        e.data = 64'd0;
        exp_q.push_back(e);
        applyStimulus(1'b1, addr, data, strb);
        r = int'(addr[4:3]);
        if (!exp_err) begin
            for (int k = 0; k < 4; k++) begin
                if (strb[k] && addr[11:8] == 4'd1) a_m[r][k] = data[k*16 +: 16];
                if (strb[k] && addr[11:8] == 4'd2) b_m[r][k] = data[k*16 +: 16];
            end
        end
    endtask

    // Issue START and update the model with the expected product
    task automatic start_run(input string tag, input int n, input int k, input int m,
                             input int wr, input int rd, input bit bias);
        logic [63:0] w;
        longint      s;
        bit          bias_on;
        w = 64'(((m-1) << 12) | ((k-1) << 10) | ((n-1) << 8) |
                (int'(bias) << 5) | (rd << 3) | (wr << 1) | 1);
        bus_write(tag, mk_addr(0, 0, 0), w, 4'hF, 1'b0);
        ctrl_m  = w & CTRL_MASK;
        bias_on = bias & BIAS_BUILD;
        flags_m = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                if (i < n && j < m) begin
                    s = 0;
                    for (int kk = 0; kk < k; kk++)
                        s += longint'($signed(a_m[i][kk])) * longint'($signed(b_m[kk][j]));
                    if (bias_on) s += longint'($signed(sp_m[rd][i][j]));
                    sp_m[wr][i][j] = s[15:0];
                    if (s > 32767 || s < -32768) flags_m[i*4+j] = 1'b1;
                end else begin
                    sp_m[wr][i][j] = '0;
                end
            end
    endtask

    // Count busy cycles after START, bounded
    task automatic wait_busy(input string tag, input int exp_cycles);
        int cnt;
        cnt = 0;
        @(negedge clk_i);
        while (busy_o === 1'b1 && cnt < 2000) begin
            cnt++;
            @(negedge clk_i);
        end
        if (exp_cycles >= 0) checkOutput({tag, "_busy_cycles"}, 64'(cnt), 64'(exp_cycles));
        checkOutput({tag, "_busy_clear"}, 64'(busy_o), 64'd0);
    endtask

    task automatic read_target(input string tag, input int t);
        for (int r = 0; r < 4; r++)
            bus_read($sformatf("%s_t%0d_row%0d", tag, t, r), mk_addr(4, t, r));
        bus_read({tag, "_flags"}, mk_addr(3, 0, 0));
    endtask

    // Overflow/boundary table: A[0][0], B[0][0]
    logic [15:0] ovf_a [3] = '{16'h7FFF, 16'h8000, 16'h8000};
    logic [15:0] ovf_b [3] = '{16'h0002, 16'h0001, 16'hFFFF};

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b0;
        bus.paddr_i   = '0;
        bus.pwdata_i  = '0;
        bus.pstrb_i   = '0;
        model_reset();

        $display("[TB] reset");
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset_busy", 64'(busy_o), 64'd0);
        checkOutput("reset_pready", 64'(bus.pready_o), 64'd0);
        @(posedge clk_i); #1;
        reset_ni = 1'b1;
        bus_read("reset_ctrl", mk_addr(0, 0, 0));
        bus_read("reset_a0", mk_addr(1, 0, 0));
        bus_read("reset_flags", mk_addr(3, 0, 0));
        bus_read("reset_sp0", mk_addr(4, 0, 0));

        $display("[TB] identity 4x4x4");
        for (int r = 0; r < 4; r++) begin
            bus_write("wr_a_id", mk_addr(1, 0, r), 64'h1 << (r*16), 4'hF, 1'b0);
            bus_write("wr_b_seq", mk_addr(2, 0, r),
                      {16'(4*r+4), 16'(4*r+3), 16'(4*r+2), 16'(4*r+1)}, 4'hF, 1'b0);
        end
        start_run("start_id", 4, 4, 4, 1, 0, 1'b0);
        wait_busy("id", 65);
        read_target("id", 1);
        bus_read("id_ctrl", mk_addr(0, 0, 0));

        $display("[TB] 2x3x2 with stale target contents");
        bus_write("wr_a0", mk_addr(1, 0, 0), {16'd0, 16'd3, 16'd2, 16'd1}, 4'hF, 1'b0);
        bus_write("wr_b0", mk_addr(2, 0, 0), {16'd0, 16'd0, 16'd0, 16'd1}, 4'hF, 1'b0);
        bus_write("wr_b1", mk_addr(2, 0, 1), {16'd0, 16'd0, 16'd1, 16'd0}, 4'hF, 1'b0);
        bus_write("wr_b2", mk_addr(2, 0, 2), {16'd0, 16'd0, 16'd1, 16'd1}, 4'hF, 1'b0);
        start_run("start_233", 2, 3, 2, 1, 0, 1'b0);
        wait_busy("r233", 13);
        read_target("r233", 1);

        $display("[TB] overflow boundaries");
        for (int c = 0; c < 3; c++) begin
            bus_write("wr_a00", mk_addr(1, 0, 0), {48'd0, ovf_a[c]}, 4'b0001, 1'b0);
            bus_write("wr_b00", mk_addr(2, 0, 0), {48'd0, ovf_b[c]}, 4'b0001, 1'b0);
            start_run("start_ovf", 1, 1, 1, 0, 0, 1'b0);
            wait_busy($sformatf("ovf%0d", c), 2);
            bus_read($sformatf("ovf%0d_sp0", c), mk_addr(4, 0, 0));
            bus_read($sformatf("ovf%0d_flags", c), mk_addr(3, 0, 0));
        end

        $display("[TB] bias");
        bus_write("wr_a00_3", mk_addr(1, 0, 0), 64'd3, 4'b0001, 1'b0);
        bus_write("wr_b00_3", mk_addr(2, 0, 0), 64'd3, 4'b0001, 1'b0);
        start_run("start_bias", 1, 1, 1, 2, 1, 1'b1);
        wait_busy("bias", 2);
        bus_read("bias_t2_row0", mk_addr(4, 2, 0));
        bus_read("bias_ctrl", mk_addr(0, 0, 0));
        start_run("start_bias_same", 1, 1, 1, 1, 1, 1'b1);
        wait_busy("bias_same", 2);
        bus_read("bias_same_t1_row0", mk_addr(4, 1, 0));

        $display("[TB] error responses");
        bus_write("wr_flags", mk_addr(3, 0, 0), 64'hFFFF, 4'hF, 1'b1);
        bus_read("flags_after", mk_addr(3, 0, 0));
        bus_write("wr_sp", mk_addr(4, 1, 0), 64'hDEAD_BEEF, 4'hF, 1'b1);
        bus_read("sp_after", mk_addr(4, 1, 0));
        bus_read("rd_region7", mk_addr(7, 0, 0));
        bus_write("wr_region5", mk_addr(5, 0, 0), 64'h1234, 4'hF, 1'b1);
        bus_write("wr_a_strb", mk_addr(1, 0, 0), 64'h4444_3333_2222_1111, 4'b0010, 1'b0);
        bus_read("a_strb_row0", mk_addr(1, 0, 0));

        start_run("start_busyprobe", 4, 4, 4, 3, 0, 1'b0);
        bus_write("wr_a_busy", mk_addr(1, 0, 0), 64'hFFFF_FFFF, 4'hF, 1'b1);
        bus_read_err("rd_busy", mk_addr(0, 0, 0));
        wait_busy("busyprobe", -1);
        bus_read("a_after_busy", mk_addr(1, 0, 0));
        read_target("busyprobe", 3);

        $display("[TB] reset during compute");
        start_run("start_abort", 4, 4, 4, 1, 0, 1'b0);
        repeat (10) @(posedge clk_i);
        #1;
        reset_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        model_reset();
        @(negedge clk_i);
        checkOutput("abort_busy", 64'(busy_o), 64'd0);
        bus_read("abort_ctrl", mk_addr(0, 0, 0));
        bus_read("abort_sp1", mk_addr(4, 1, 0));
        bus_read("abort_a0", mk_addr(1, 0, 0));

        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
